tone_detector: RTL and testbench

- Receive-side counterpart of the buzzer tone generator: measures the period of an incoming square wave, classifies it as tone A (440 Hz) or tone B (880 Hz), and asserts a lock indication after a run of consistent periods.
- Sits between an external comparator/pin (or a loopback of the buzzer line) and the clock/alarm control logic.
- Used for self-test of the buzzer path and for detecting an external alert tone.

---
 rtl/tone_pkg.sv | 24 ++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/tone_detector.sv | 165 ++++++++++++++++
 tb/tb_tone_detector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone detector: FSM states, period class
// codes and the nominal-period calculation.
`timescale 1ns/1ps
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_A   = 2'b00,
    CLS_B   = 2'b01,
    CLS_INV = 2'b10
  } cls_t;

  // Clocks per cycle of a tone, truncated the same way the period counter counts.
  function automatic int unsigned nominal_period(input int unsigned clk_hz,
                                                 input int unsigned tone_hz);
    return clk_hz / tone_hz;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous pin into the clock domain and emits a one-cycle
// pulse on each synchronized rising edge.
`timescale 1ns/1ps
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: sequential state uses non-blocking assignments so the three flops
  // shift together on the same edge instead of collapsing into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  // meta may be metastable, so only sync and hist feed logic.
  assign rise = sync & ~hist;

endmodule

// File: rtl/tone_detector.sv
// Measures the period of a square wave, classifies it as tone A or tone B,
// and locks after a run of consistent periods; times out on silence.
`timescale 1ns/1ps
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TONE_A_HZ  = 440,
  parameter int unsigned TONE_B_HZ  = 880,
  parameter int unsigned TOL_CYC    = 1024,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 24
) (
  input  logic             Clk_50MHz,
  input  logic             Rst_n,
  input  logic             Tone_in,
  output logic [CNT_W-1:0] Period_out,
  output logic             Period_strobe,
  output logic [1:0]       Period_class,
  output logic             Tone_detected,
  output logic             Tone_id,
  output logic             Timeout
);

  localparam int unsigned NOM_A = nominal_period(CLK_HZ, TONE_A_HZ);
  localparam int unsigned NOM_B = nominal_period(CLK_HZ, TONE_B_HZ);
  localparam int unsigned XW    = CNT_W + 1;

  localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(2 * NOM_A);
  localparam logic [XW-1:0]    NOM_A_X     = XW'(NOM_A);
  localparam logic [XW-1:0]    NOM_B_X     = XW'(NOM_B);
  localparam logic [XW-1:0]    TOL_X       = XW'(TOL_CYC);
  localparam logic [3:0]       LOCK_N      = 4'(LOCK_COUNT);

  logic             edge_pulse;
  logic [CNT_W-1:0] count;
  logic [XW-1:0]    p_ext;
  logic [XW-1:0]    diff_a;
  logic [XW-1:0]    diff_b;
  cls_t             cls;

  state_t           state_q, state_d;
  logic [3:0]       match_q, match_d;
  cls_t             last_cls_q, last_cls_d;
  cls_t             class_q, class_d;
  logic [CNT_W-1:0] period_d;
  logic             strobe_d;
  logic             det_d;
  logic             id_d;
  logic             tmo_d;

  sync_edge_detect u_sync (
    .clk   (Clk_50MHz),
    .rst_n (Rst_n),
    .din   (Tone_in),
    .rise  (edge_pulse)
  );

  // Count value at an edge pulse equals the clocks since the previous pulse.
  always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (edge_pulse) begin
      count <= CNT_W'(1);
    end else if (count < TIMEOUT_CYC) begin
      count <= count + CNT_W'(1);
    end
  end

  // One extra bit keeps both subtraction directions free of wrap-around.
  always_comb begin
    p_ext  = {1'b0, count};
    diff_a = (p_ext >= NOM_A_X) ? (p_ext - NOM_A_X) : (NOM_A_X - p_ext);
    diff_b = (p_ext >= NOM_B_X) ? (p_ext - NOM_B_X) : (NOM_B_X - p_ext);
    cls    = CLS_INV;
    if (diff_a <= TOL_X) begin
      cls = CLS_A;
    end else if (diff_b <= TOL_X) begin
      cls = CLS_B;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    last_cls_d = last_cls_q;
    class_d    = class_q;
    period_d   = Period_out;
    strobe_d   = 1'b0;
    det_d      = Tone_detected;
    id_d       = Tone_id;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (edge_pulse) begin
          state_d = ACQUIRE;
          match_d = '0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (edge_pulse) begin
          period_d   = count;
          class_d    = cls;
          strobe_d   = 1'b1;
          last_cls_d = cls;
          if (cls == CLS_INV) begin
            state_d = ACQUIRE;
            match_d = '0;
            det_d   = 1'b0;
          end else if (cls != last_cls_q) begin
            state_d = ACQUIRE;
            match_d = 4'd1;
            det_d   = 1'b0;
          end else if (state_q == ACQUIRE) begin
            match_d = match_q + 4'd1;
          end
          if (state_q == ACQUIRE && cls != CLS_INV && match_d == LOCK_N) begin
            state_d = LOCKED;
            det_d   = 1'b1;
            id_d    = cls[0];
          end
        end else if (count == TIMEOUT_CYC) begin
          state_d = IDLE;
          match_d = '0;
          det_d   = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        match_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= IDLE;
      match_q       <= '0;
      last_cls_q    <= CLS_A;
      class_q       <= CLS_A;
      Period_out    <= '0;
      Period_strobe <= 1'b0;
      Tone_detected <= 1'b0;
      Tone_id       <= 1'b0;
      Timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_q       <= match_d;
      last_cls_q    <= last_cls_d;
      class_q       <= class_d;
      Period_out    <= period_d;
      Period_strobe <= strobe_d;
      Tone_detected <= det_d;
      Tone_id       <= id_d;
      Timeout       <= tmo_d;
    end
  end

  assign Period_class = class_q;

endmodule

// File: tb/tb_tone_detector.sv
// Randomized bench for tone_detector: an event-level model predicts every
// strobe and timeout (cycle and contents), compared against what the DUT emits.
`timescale 1ns/1ps
module tb_tone_detector;

  // Scaled clock so a tone period is about a thousand cycles.
  localparam int unsigned CLK_HZ = 440_000;
  localparam int unsigned TA     = 440;
  localparam int unsigned TB     = 880;
  localparam int          TOL    = 20;
  localparam int          LOCK   = 4;
  localparam int          W      = 16;
  localparam int          NOM_A  = int'(CLK_HZ / TA);
  localparam int          NOM_B  = int'(CLK_HZ / TB);
  localparam int          TMO    = 2 * NOM_A;
  localparam int          LAT    = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tone_in;
  logic [W-1:0] period_out;
  logic         period_strobe;
  logic [1:0]   period_class;
  logic         tone_detected;
  logic         tone_id;
  logic         timeout;

  tone_detector #(
    .CLK_HZ     (CLK_HZ),
    .TONE_A_HZ  (TA),
    .TONE_B_HZ  (TB),
    .TOL_CYC    (TOL),
    .LOCK_COUNT (LOCK),
    .CNT_W      (W)
  ) dut (
    .Clk_50MHz     (clk),
    .Rst_n         (rst_n),
    .Tone_in       (tone_in),
    .Period_out    (period_out),
    .Period_strobe (period_strobe),
    .Period_class  (period_class),
    .Tone_detected (tone_detected),
    .Tone_id       (tone_id),
    .Timeout       (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int at;
    bit tmo;
    int period;
    int cls;
    bit det;
    bit id;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];

  function automatic ev_t mk(input int at, input bit tmo, input int period,
                             input int cls, input bit det, input bit id);
    ev_t e;
    e.at = at; e.tmo = tmo; e.period = period;
    e.cls = cls; e.det = det; e.id = id;
    return e;
  endfunction

  always @(negedge clk) begin
    if (period_strobe)
      act_q.push_back(mk(cyc, 1'b0, int'(period_out), int'(period_class), tone_detected, tone_id));
    if (timeout)
      act_q.push_back(mk(cyc, 1'b1, 0, 0, tone_detected, tone_id));
  end

  // Reference model: works on rise times of the pin and runs of equal classes.
  bit have_ref;
  int last_rise;
  int run_len;
  int run_cls;
  bit m_det;
  bit m_id;

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int classify(input int p);
    if (abs_i(p - NOM_A) <= TOL) return 0;
    if (abs_i(p - NOM_B) <= TOL) return 1;
    return 2;
  endfunction

  function automatic void model_reset();
    have_ref = 1'b0;
    run_len  = 0;
    run_cls  = 0;
    m_det    = 1'b0;
    m_id     = 1'b0;
  endfunction

  function automatic void model_timeout();
    run_len = 0;
    m_det   = 1'b0;
    exp_q.push_back(mk(last_rise + TMO + LAT, 1'b1, 0, 0, 1'b0, m_id));
    have_ref = 1'b0;
  endfunction

  function automatic void model_edge(input int now);
    int gap;
    int c;
    if (have_ref) begin
      gap = now - last_rise;
      if (gap > TMO) begin
        model_timeout();
      end else begin
        c = classify(gap);
        if (c == 2) begin
          run_len = 0;
        end else if (run_len > 0 && c == run_cls) begin
          run_len++;
        end else begin
          run_len = 1;
          run_cls = c;
        end
        m_det = (run_len >= LOCK);
        if (m_det) m_id = (run_cls == 1);
        exp_q.push_back(mk(now + LAT, 1'b0, gap, c, m_det, m_id));
      end
    end
    have_ref  = 1'b1;
    last_rise = now;
  endfunction

  function automatic void model_flush(input int now);
    if (have_ref && (now - last_rise) > TMO + LAT) model_timeout();
  endfunction

  // Raise the pin now, keep the next rising edge exactly gap cycles away.
  task automatic wave(input int gap);
    model_edge(cyc);
    tone_in = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk);
      if (i == gap / 2) tone_in = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".period"}, period_out, 0);
    check({tag, ".strobe"}, period_strobe, 0);
    check({tag, ".class"},  period_class, 0);
    check({tag, ".det"},    tone_detected, 0);
    check({tag, ".id"},     tone_id, 0);
    check({tag, ".tmo"},    timeout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d events, expected %0d",
             act_q.size(), exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int kind;
    int len;
    int n;

    model_reset();
    rst_n   = 1'b1;
    tone_in = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 440 Hz, then 880 Hz while locked.
    repeat (6) wave(NOM_A);
    repeat (6) wave(NOM_B);

    // Random runs of jittered A, jittered B and out-of-band periods.
    for (int r = 0; r < 6; r++) begin
      kind = int'($urandom_range(0, 2));
      len  = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        case (kind)
          0:       gap = NOM_A - TOL + int'($urandom_range(0, 2 * TOL));
          1:       gap = NOM_B - TOL + int'($urandom_range(0, 2 * TOL));
          default: gap = NOM_B + TOL + 1 + int'($urandom_range(0, NOM_A - NOM_B - 2 * TOL - 2));
        endcase
        wave(gap);
      end
    end

    // Tolerance edges: exactly TOL is accepted, TOL+1 is not.
    wave(NOM_A + TOL);
    wave(NOM_A - TOL);
    wave(NOM_A + TOL + 1);
    wave(NOM_B - TOL);
    wave(NOM_B + TOL);
    wave(NOM_B - TOL - 1);
    wave(NOM_B + TOL + 1);

    // Out-of-band tone (500 Hz at full scale) never locks.
    repeat (6) wave(NOM_A * TA / 500);

    // Lock, then silence one cycle past the limit, then an edge right at it.
    repeat (5) wave(NOM_A);
    wave(TMO + 1);
    repeat (2) wave(NOM_A);
    wave(TMO);
    repeat (5) wave(NOM_A);

    // Asynchronous reset in the middle of a locked period.
    wave(300);
    check("pre_rst.det", tone_detected, 1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    repeat (6) wave(NOM_A);

    // Final silence ends in a timeout.
    repeat (TMO + 20) @(negedge clk);
    model_flush(cyc);
    check("end.det", tone_detected, 0);

    check("ev.count", act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("ev%0d.at", i),  act_q[i].at,  exp_q[i].at);
      check($sformatf("ev%0d.tmo", i), act_q[i].tmo, exp_q[i].tmo);
      check($sformatf("ev%0d.det", i), act_q[i].det, exp_q[i].det);
      check($sformatf("ev%0d.id", i),  act_q[i].id,  exp_q[i].id);
      if (!exp_q[i].tmo) begin
        check($sformatf("ev%0d.period", i), act_q[i].period, exp_q[i].period);
        check($sformatf("ev%0d.class", i),  act_q[i].cls,    exp_q[i].cls);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
